// File: rtl/banqi_pkg.sv
// banqi_pkg: shared Banqi piece encoding, FSM states and the unshuffled setup table.
package banqi_pkg;

    localparam logic COLOR_RED       = 1'b0;
    localparam logic COLOR_BLACK     = 1'b1;
    localparam logic STATE_COVERED   = 1'b0;
    localparam logic STATE_UNCOVERED = 1'b1;

    localparam logic [2:0] PIECE_NONE    = 3'd0;
    localparam logic [2:0] PIECE_PAWN    = 3'd1;
    localparam logic [2:0] PIECE_CANNON  = 3'd2;
    localparam logic [2:0] PIECE_KNIGHT  = 3'd3;
    localparam logic [2:0] PIECE_BISHOP  = 3'd4;
    localparam logic [2:0] PIECE_ROOK    = 3'd5;
    localparam logic [2:0] PIECE_QUEEN   = 3'd6;
    localparam logic [2:0] PIECE_KING    = 3'd7;

    typedef struct packed {
        logic       color;
        logic [2:0] piece;
        logic       state;
    } piece_t;

    typedef enum logic [2:0] {S_IDLE, S_INIT, S_RD, S_EXEC, S_WR_SRC, S_FIN} fsm_t;

    // Squares 0-15 are black, 16-31 red; outer rows are back ranks, inner rows pawn rows.
    function automatic piece_t setup_piece(input logic [4:0] i);
        logic       back;
        logic [2:0] kind;
        back = (i[4:3] == 2'b00) || (i[4:3] == 2'b11);
        case (i[2:0])
            3'd1, 3'd6: kind = back ? PIECE_KNIGHT : PIECE_PAWN;
            3'd2:       kind = back ? PIECE_BISHOP : PIECE_PAWN;
            3'd3:       kind = back ? PIECE_QUEEN  : PIECE_CANNON;
            3'd4:       kind = back ? PIECE_KING   : PIECE_CANNON;
            3'd5:       kind = back ? PIECE_BISHOP : PIECE_QUEEN;
            default:    kind = back ? PIECE_ROOK   : PIECE_PAWN;
        endcase
        return '{color: i[4] ? COLOR_RED : COLOR_BLACK, piece: kind, state: STATE_COVERED};
    endfunction

endpackage

// File: rtl/banqi_lfsr5.sv
// banqi_lfsr5: free-running 5-bit Fibonacci LFSR (x^5+x^3+1); nonzero reset keeps it out of the lock-up state.
module banqi_lfsr5 #(
    parameter logic [4:0] RESET_VAL = 5'h15
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    output logic [4:0] o_q
);

    logic [4:0] r_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_q <= RESET_VAL;
        else          r_q <= {r_q[3:0], r_q[4] ^ r_q[2]};
    end

    assign o_q = r_q;

endmodule

// File: rtl/board_write_sequencer.sv
// board_write_sequencer: sole owner of the board write port; loads the initial board
// and turns FLIP/MOVE commands into one or two square writes while tracking side-to-move.
module board_write_sequencer
    import banqi_pkg::*;
#(
    parameter bit         SHUFFLE    = 1'b1,
    parameter logic [4:0] LFSR_RESET = 5'h15
) (
    input  logic       CLOCK_50,
    input  logic       resetn,
    input  logic       start_init,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_op,
    input  logic [4:0] cmd_src,
    input  logic [4:0] cmd_dst,
    output logic [4:0] rd_addr,
    input  logic [4:0] rd_piece,
    output logic       wr_en,
    output logic [4:0] wr_addr,
    output logic [4:0] wr_piece,
    output logic       init_busy,
    output logic       turn,
    output logic       done,
    output logic       error
);

    fsm_t       r_state, w_next;
    logic [4:0] r_i, r_seed, r_src, r_dst, r_rd_addr, w_lfsr;
    logic       r_op, r_turn, r_ok;
    piece_t     r_p;
    logic       w_accept, w_flip_ok, w_move_ok;

    banqi_lfsr5 #(.RESET_VAL(LFSR_RESET)) u_lfsr (
        .i_clk  (CLOCK_50),
        .i_rst_n(resetn),
        .o_q    (w_lfsr)
    );

    assign cmd_ready = (r_state == S_IDLE) && !start_init;
    assign w_accept  = cmd_valid && cmd_ready;
    assign w_flip_ok = !r_op && (r_p.state == STATE_COVERED);
    assign w_move_ok = r_op && (r_p.state == STATE_UNCOVERED) && (r_p.piece != PIECE_NONE)
                       && (r_p.color == r_turn) && (r_src != r_dst);
    assign rd_addr   = r_rd_addr;
    assign init_busy = r_state == S_INIT;
    assign turn      = r_turn;
    assign done      = (r_state == S_FIN) && r_ok;
    assign error     = (r_state == S_FIN) && !r_ok;

    // Write strobe is decoded from state so an async reset drops it immediately.
    always_comb begin
        w_next   = r_state;
        wr_en    = 1'b0;
        wr_addr  = 5'd0;
        wr_piece = 5'd0;
        case (r_state)
            S_IDLE:   w_next = start_init ? S_INIT : (w_accept ? S_RD : S_IDLE);
            S_INIT: begin
                wr_en    = 1'b1;
                wr_addr  = r_i ^ r_seed;
                wr_piece = setup_piece(r_i);
                w_next   = (r_i == 5'd31) ? S_IDLE : S_INIT;
            end
            S_RD:     w_next = S_EXEC;
            S_EXEC: begin
                wr_en    = w_flip_ok || w_move_ok;
                wr_addr  = w_flip_ok ? r_src : r_dst;
                wr_piece = w_flip_ok ? {r_p[4:1], STATE_UNCOVERED} : r_p;
                w_next   = w_move_ok ? S_WR_SRC : S_FIN;
            end
            S_WR_SRC: begin
                wr_en   = 1'b1;
                wr_addr = r_src;
                w_next  = S_FIN;
            end
            default:  w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            r_state   <= S_IDLE;
            r_i       <= 5'd0;
            r_seed    <= 5'd0;
            r_src     <= 5'd0;
            r_dst     <= 5'd0;
            r_rd_addr <= 5'd0;
            r_op      <= 1'b0;
            r_turn    <= COLOR_RED;
            r_ok      <= 1'b0;
            r_p       <= '0;
        end else begin
            r_state <= w_next;
            case (r_state)
                S_IDLE: begin
                    if (start_init) begin
                        r_i    <= 5'd0;
                        r_seed <= SHUFFLE ? w_lfsr : 5'd0;
                    end else if (w_accept) begin
                        r_op      <= cmd_op;
                        r_src     <= cmd_src;
                        r_dst     <= cmd_dst;
                        r_rd_addr <= cmd_src;
                    end
                end
                S_INIT: begin
                    r_i <= r_i + 5'd1;
                    if (r_i == 5'd31) r_turn <= COLOR_RED;
                end
                S_RD:     r_p <= rd_piece;
                S_EXEC: begin
                    r_ok <= w_flip_ok || w_move_ok;
                    if (w_flip_ok) r_turn <= ~r_turn;
                end
                S_WR_SRC: r_turn <= ~r_turn;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_board_write_sequencer.sv
// tb_board_write_sequencer: directed, table-driven checks of board load, FLIP/MOVE sequencing and reset abort.
module tb_board_write_sequencer;

    logic       CLOCK_50 = 1'b0;
    logic       resetn = 1'b0, start_init = 1'b0, cmd_valid = 1'b0, cmd_op = 1'b0;
    logic [4:0] cmd_src = 5'd0, cmd_dst = 5'd0, rd_piece = 5'd0;
    logic       cmd_ready, wr_en, init_busy, turn, done, error;
    logic [4:0] rd_addr, wr_addr, wr_piece;

    int n_chk = 0, n_pass = 0;

    always #5 CLOCK_50 = ~CLOCK_50;

    board_write_sequencer #(.SHUFFLE(1'b0), .LFSR_RESET(5'h15)) dut (
        .CLOCK_50  (CLOCK_50),
        .resetn    (resetn),
        .start_init(start_init),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_src   (cmd_src),
        .cmd_dst   (cmd_dst),
        .rd_addr   (rd_addr),
        .rd_piece  (rd_piece),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_piece  (wr_piece),
        .init_busy (init_busy),
        .turn      (turn),
        .done      (done),
        .error     (error)
    );

    // Piece codes: P=1 C=2 N=3 B=4 R=5 Q=6 K=7
    localparam int BACK_K [8] = '{5, 3, 4, 6, 7, 4, 3, 5};
    localparam int PAWN_K [8] = '{1, 1, 1, 2, 2, 6, 1, 1};

    typedef struct {
        logic       op;
        logic [4:0] src, dst, rd;
        int         n_wr;
        logic [4:0] a1, p1, a2, p2;
        int         done_at, err_at;
        logic       turn_after;
    } vec_t;

    vec_t vt [8];

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    endtask

    function automatic logic [4:0] exp_setup(input int k);
        logic [2:0] kind;
        kind = 3'((k < 8 || k >= 24) ? BACK_K[k % 8] : PAWN_K[k % 8]);
        return {k < 16, kind, 1'b0};
    endfunction

    task automatic run_cmd(input vec_t v, input int idx);
        int         n, d_at, e_at, w1_at;
        logic [4:0] wa [2];
        logic [4:0] wp [2];
        n = 0; d_at = 0; e_at = 0; w1_at = 0;
        wa[0] = 5'd0; wa[1] = 5'd0; wp[0] = 5'd0; wp[1] = 5'd0;
        @(negedge CLOCK_50);
        cmd_op = v.op; cmd_src = v.src; cmd_dst = v.dst; rd_piece = v.rd; cmd_valid = 1'b1;
        #1 chk($sformatf("v%0d cmd_ready", idx), int'(cmd_ready), 1);
        @(posedge CLOCK_50);
        #1 cmd_valid = 1'b0;
        for (int c = 1; c <= 6; c++) begin
            @(negedge CLOCK_50);
            if (c == 1) chk($sformatf("v%0d rd_addr", idx), int'(rd_addr), int'(v.src));
            if (wr_en) begin
                if (n == 0) w1_at = c;
                if (n < 2) begin wa[n] = wr_addr; wp[n] = wr_piece; end
                n++;
            end
            if (done && d_at == 0) d_at = c;
            if (error && e_at == 0) e_at = c;
        end
        chk($sformatf("v%0d n_writes", idx), n, v.n_wr);
        if (v.n_wr >= 1) begin
            chk($sformatf("v%0d wr1_cycle", idx), w1_at, 2);
            chk($sformatf("v%0d wr1", idx), int'({wa[0], wp[0]}), int'({v.a1, v.p1}));
        end
        if (v.n_wr >= 2) chk($sformatf("v%0d wr2", idx), int'({wa[1], wp[1]}), int'({v.a2, v.p2}));
        chk($sformatf("v%0d done_at", idx), d_at, v.done_at);
        chk($sformatf("v%0d error_at", idx), e_at, v.err_at);
        chk($sformatf("v%0d turn", idx), int'(turn), int'(v.turn_after));
    endtask

    task automatic do_init(input logic with_cmd, input int abort_at);
        @(negedge CLOCK_50);
        start_init = 1'b1;
        if (with_cmd) begin
            cmd_valid = 1'b1; cmd_op = 1'b1; cmd_src = 5'd3; cmd_dst = 5'd20; rd_piece = 5'b00011;
        end
        @(posedge CLOCK_50);
        #1 start_init = 1'b0; cmd_valid = 1'b0;
        for (int k = 0; k < 32; k++) begin
            @(negedge CLOCK_50);
            if (k == abort_at) begin
                resetn = 1'b0;
                #1 chk("abort outputs {wr_en,init_busy,turn,done,error,rd_addr}",
                       int'({wr_en, init_busy, turn, done, error, rd_addr}), 0);
                @(negedge CLOCK_50);
                resetn = 1'b1;
                #1 chk("abort idle cmd_ready", int'(cmd_ready), 1);
                return;
            end
            chk($sformatf("init k=%0d {wr_en,busy,ready,addr,piece}", k),
                int'({wr_en, init_busy, cmd_ready, wr_addr, wr_piece}),
                int'({1'b1, 1'b1, 1'b0, k[4:0], exp_setup(k)}));
        end
        @(negedge CLOCK_50);
        chk("init end {wr_en,init_busy,turn}", int'({wr_en, init_busy, turn}), 0);
        if (with_cmd) begin
            for (int c = 0; c < 5; c++) begin
                @(negedge CLOCK_50);
                chk($sformatf("dropped cmd quiet c=%0d", c), int'({wr_en, done, error}), 0);
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        vt[0] = '{1'b0, 5'd28, 5'd0,  5'b01110, 1, 5'd28, 5'b01111, 5'd0, 5'd0, 3, 0, 1'b1};
        vt[1] = '{1'b1, 5'd4,  5'd12, 5'b11111, 2, 5'd12, 5'b11111, 5'd4, 5'd0, 4, 0, 1'b0};
        vt[2] = '{1'b1, 5'd3,  5'd5,  5'b11110, 0, 5'd0,  5'd0,     5'd0, 5'd0, 0, 3, 1'b0};
        vt[3] = '{1'b1, 5'd3,  5'd5,  5'b11111, 0, 5'd0,  5'd0,     5'd0, 5'd0, 0, 3, 1'b0};
        vt[4] = '{1'b0, 5'd7,  5'd0,  5'b01011, 0, 5'd0,  5'd0,     5'd0, 5'd0, 0, 3, 1'b0};
        vt[5] = '{1'b1, 5'd9,  5'd9,  5'b00011, 0, 5'd0,  5'd0,     5'd0, 5'd0, 0, 3, 1'b0};
        vt[6] = '{1'b1, 5'd9,  5'd10, 5'b00001, 0, 5'd0,  5'd0,     5'd0, 5'd0, 0, 3, 1'b0};
        vt[7] = '{1'b1, 5'd9,  5'd10, 5'b00011, 2, 5'd10, 5'b00011, 5'd9, 5'd0, 4, 0, 1'b1};

        repeat (3) @(posedge CLOCK_50);
        #1 chk("reset {wr_en,init_busy,turn,done,error,rd_addr}",
               int'({wr_en, init_busy, turn, done, error, rd_addr}), 0);
        @(negedge CLOCK_50);
        resetn = 1'b1;
        #1 chk("post-reset cmd_ready", int'(cmd_ready), 1);

        do_init(1'b0, -1);
        for (int v = 0; v < 8; v++) run_cmd(vt[v], v);
        do_init(1'b0, 10);
        do_init(1'b1, -1);
        run_cmd(vt[0], 8);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
